// File: rtl/mips_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_fetch_pkg
//  Description : Shared constants for the instruction fetch unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_fetch_pkg;

    // Width of an instruction word returned by instruction memory
    localparam int C_INSTR_W = 32;

    // Byte distance between sequential instructions
    localparam int C_PC_INC = 4;

    // Default number of fetch slots (in flight + queued)
    localparam int C_DEPTH = 2;

    // Default fetch PC after reset
    localparam logic [31:0] C_RESET_PC = 32'h0040_0000;

    // Width of a counter able to hold the values 0..depth
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : mips_fetch_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Small synchronous FIFO with flush, simultaneous push/pop and
//                synchronous active-low reset. DEPTH must be a power of two.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int C_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [C_AW-1:0]  r_wr_ptr;
    logic [C_AW-1:0]  r_rd_ptr;
    logic [C_AW:0]    r_count;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign w_full    = (r_count == (C_AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head_data = r_mem[r_rd_ptr];

    // Guard the pointers so a misuse cannot corrupt the occupancy count
    assign w_push = push && !w_full;
    assign w_pop  = pop && !empty;

    // Pointer and occupancy tracking; flush empties the FIFO in one cycle
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + (C_AW+1)'(w_push) - (C_AW+1)'(w_pop);
        end
    end

    // Storage array; contents need no reset because empty gates their use
    always_ff @(posedge clk) begin
        if (reset && !flush && w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // The owner's credit scheme must never overfill or underflow the FIFO
    always_ff @(posedge clk) begin
        if (reset && !flush) begin
            assert (!(push && w_full));
            assert (!(pop && empty));
        end
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Owns the fetch PC, issues in-order instruction memory reads,
//                pairs each response with its PC and queues {pc, instr} for
//                decode. Redirects reload the PC, flush and drop stale data.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter int           N        = 32,
    parameter logic [N-1:0] RESET_PC = N'(C_RESET_PC),
    parameter int           DEPTH    = C_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 redirect_valid,
    input  logic [N-1:0]         redirect_pc,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [N-1:0]         imem_req_addr,
    input  logic                 imem_rsp_valid,
    input  logic [C_INSTR_W-1:0] imem_rsp_data,
    output logic                 if_valid,
    input  logic                 if_ready,
    output logic [N-1:0]         if_pc,
    output logic [C_INSTR_W-1:0] if_instr
);

    localparam int C_CW = cnt_width(DEPTH);
    localparam int C_SW = C_CW + 2;
    localparam int C_QW = N + C_INSTR_W;

    logic [N-1:0]      r_fetch_pc;
    logic [C_CW-1:0]   r_live;
    logic [C_CW-1:0]   r_discard;
    logic [C_CW-1:0]   w_live_nxt;
    logic [C_CW-1:0]   w_discard_nxt;

    logic [C_SW-1:0]   w_occupancy;
    logic              w_accept;
    logic              w_rsp_drop;
    logic              w_rsp_take;
    logic              w_rsp_used;
    logic [N-1:0]      w_redirect_aligned;

    logic [N-1:0]      w_inf_pc;
    logic              w_inf_empty;
    logic [C_CW-1:0]   w_inf_count;

    logic [C_QW-1:0]   w_q_head;
    logic              w_q_empty;
    logic [C_CW-1:0]   w_q_count;

    // Every slot is accounted for: live requests, stale requests still owed
    // a response, and entries waiting for decode. A request is only issued
    // when its eventual response is guaranteed a queue slot.
    assign w_occupancy    = C_SW'(r_live) + C_SW'(r_discard) + C_SW'(w_q_count);
    assign imem_req_valid = reset && (w_occupancy < C_SW'(DEPTH)) && !redirect_valid;
    assign imem_req_addr  = r_fetch_pc;
    assign w_accept       = imem_req_valid && imem_req_ready;

    // Stale responses are consumed first; responses with nothing owed are ignored
    assign w_rsp_drop = imem_rsp_valid && (r_discard != '0);
    assign w_rsp_take = imem_rsp_valid && (r_discard == '0) && (r_live != '0);
    assign w_rsp_used = w_rsp_drop || w_rsp_take;

    assign w_redirect_aligned = redirect_pc & ~N'(3);

    // Live/discard bookkeeping; a redirect turns all live requests stale
    always_comb begin
        w_live_nxt    = r_live;
        w_discard_nxt = r_discard;
        if (redirect_valid) begin
            w_live_nxt    = '0;
            w_discard_nxt = r_live + r_discard - C_CW'(w_rsp_used);
        end else begin
            w_live_nxt    = r_live + C_CW'(w_accept) - C_CW'(w_rsp_take);
            w_discard_nxt = r_discard - C_CW'(w_rsp_drop);
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_live    <= '0;
            r_discard <= '0;
        end else begin
            r_live    <= w_live_nxt;
            r_discard <= w_discard_nxt;
        end
    end

    // Fetch PC: redirect target wins, otherwise advance on each accepted request
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_fetch_pc <= w_redirect_aligned;
        end else if (w_accept) begin
            r_fetch_pc <= r_fetch_pc + N'(C_PC_INC);
        end
    end

    // PCs of outstanding requests, in issue order
    sync_fifo #(
        .WIDTH (N),
        .DEPTH (DEPTH)
    ) u_inflight_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (w_accept),
        .push_data (r_fetch_pc),
        .pop       (w_rsp_take && !redirect_valid),
        .head_data (w_inf_pc),
        .empty     (w_inf_empty),
        .count     (w_inf_count)
    );

    // {pc, instr} pairs waiting for decode; a redirect ignores the same-cycle pop
    sync_fifo #(
        .WIDTH (C_QW),
        .DEPTH (DEPTH)
    ) u_out_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (w_rsp_take && !redirect_valid),
        .push_data ({w_inf_pc, imem_rsp_data}),
        .pop       (if_valid && if_ready && !redirect_valid),
        .head_data (w_q_head),
        .empty     (w_q_empty),
        .count     (w_q_count)
    );

    assign if_valid = !w_q_empty;
    assign if_pc    = if_valid ? w_q_head[C_QW-1:C_INSTR_W] : '0;
    assign if_instr = if_valid ? w_q_head[C_INSTR_W-1:0]    : '0;

    // The live counter mirrors the in-flight PC FIFO occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            assert (w_inf_count == r_live);
            assert (!(w_rsp_take && w_inf_empty));
        end
    end

endmodule : instr_fetch_unit
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Directed self-checking bench for instr_fetch_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam logic [31:0] C_RST = 32'h0040_0000;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    int errors = 0;
    int checks = 0;

    instr_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction word the memory model returns for a given address
    function automatic logic [31:0] word_for(input logic [31:0] pc);
        return pc ^ 32'hA5A5_5A5A;
    endfunction

    // Advance to just after the next rising edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if_ready       = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0; if_ready = 1'b0;
        next_cycle();
        next_cycle();
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b expected 0", imem_req_valid); end
        checks++; if (imem_req_addr !== C_RST) begin errors++; $display("FAIL rst_addr: got %h expected %h", imem_req_addr, C_RST); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_if_valid: got %b expected 0", if_valid); end
        checks++; if (if_pc !== 32'h0 || if_instr !== 32'h0) begin errors++; $display("FAIL rst_if_data: got %h/%h expected 0/0", if_pc, if_instr); end
        reset = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== C_RST) begin errors++; $display("FAIL t1_first_req: got %b/%h expected 1/%h", imem_req_valid, imem_req_addr, C_RST); end
        next_cycle();
        #1;
        checks++; if (imem_req_addr !== 32'h0040_0004) begin errors++; $display("FAIL t1_second_addr: got %h expected 00400004", imem_req_addr); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL t1_no_early_valid: got %b expected 0", if_valid); end
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = word_for(C_RST);
        next_cycle();
        imem_rsp_valid = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b1 || if_pc !== C_RST || if_instr !== word_for(C_RST)) begin errors++; $display("FAIL t1_first_out: got %b/%h/%h expected 1/%h/%h", if_valid, if_pc, if_instr, C_RST, word_for(C_RST)); end
        if_ready = 1'b1;
        next_cycle();
        #1;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL t1_after_pop: got %b expected 0", if_valid); end
    endtask

    task automatic test_stream();
        logic        pend;
        logic [31:0] pend_addr;
        logic [31:0] exp_req;
        logic [31:0] exp_pop;
        int          pops;
        int          cyc;
        do_reset();
        pend = 1'b0; pend_addr = '0; exp_req = C_RST; exp_pop = C_RST; pops = 0; cyc = 0;
        while (pops < 6 && cyc < 40) begin
            imem_rsp_valid = pend;
            imem_rsp_data  = pend ? word_for(pend_addr) : 32'h0;
            imem_req_ready = 1'b1;
            if_ready       = 1'b1;
            #1;
            pend = 1'b0;
            if (imem_req_valid) begin
                checks++; if (imem_req_addr !== exp_req) begin errors++; $display("FAIL stream_req_addr: got %h expected %h", imem_req_addr, exp_req); end
                pend = 1'b1; pend_addr = exp_req; exp_req = exp_req + 32'd4;
            end
            if (if_valid) begin
                checks++; if (if_pc !== exp_pop || if_instr !== word_for(exp_pop)) begin errors++; $display("FAIL stream_out: got %h/%h expected %h/%h", if_pc, if_instr, exp_pop, word_for(exp_pop)); end
                exp_pop = exp_pop + 32'd4; pops++;
            end
            next_cycle();
            cyc++;
        end
        checks++; if (pops != 6) begin errors++; $display("FAIL stream_timeout: got %0d pops expected 6", pops); end
        imem_rsp_valid = 1'b0; imem_req_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        imem_req_ready = 1'b1; if_ready = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== C_RST) begin errors++; $display("FAIL bp_c0_req: got %b/%h expected 1/%h", imem_req_valid, imem_req_addr, C_RST); end
        next_cycle();
        imem_rsp_valid = 1'b1; imem_rsp_data = word_for(C_RST);
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0040_0004) begin errors++; $display("FAIL bp_c1_req: got %b/%h expected 1/00400004", imem_req_valid, imem_req_addr); end
        next_cycle();
        imem_rsp_data = word_for(32'h0040_0004);
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_c2_stall: got %b expected 0", imem_req_valid); end
        next_cycle();
        imem_rsp_valid = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b0 || if_valid !== 1'b1 || if_pc !== C_RST) begin errors++; $display("FAIL bp_full: got %b/%b/%h expected 0/1/%h", imem_req_valid, if_valid, if_pc, C_RST); end
        next_cycle();
        if_ready = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b0 || if_pc !== C_RST || if_instr !== word_for(C_RST)) begin errors++; $display("FAIL bp_pop0: got %b/%h/%h expected 0/%h/%h", imem_req_valid, if_pc, if_instr, C_RST, word_for(C_RST)); end
        next_cycle();
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0040_0008) begin errors++; $display("FAIL bp_resume: got %b/%h expected 1/00400008", imem_req_valid, imem_req_addr); end
        checks++; if (if_pc !== 32'h0040_0004 || if_instr !== word_for(32'h0040_0004)) begin errors++; $display("FAIL bp_pop1: got %h/%h expected 00400004/%h", if_pc, if_instr, word_for(32'h0040_0004)); end
        next_cycle();
        imem_rsp_valid = 1'b1; imem_rsp_data = word_for(32'h0040_0008); imem_req_ready = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b expected 0", if_valid); end
        next_cycle();
        imem_rsp_valid = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0040_0008 || if_instr !== word_for(32'h0040_0008)) begin errors++; $display("FAIL bp_pop2: got %b/%h/%h expected 1/00400008/%h", if_valid, if_pc, if_instr, word_for(32'h0040_0008)); end
        next_cycle();
    endtask

    task automatic test_redirect_drop();
        do_reset();
        imem_req_ready = 1'b1; if_ready = 1'b1;
        next_cycle();
        #1;
        checks++; if (imem_req_addr !== 32'h0040_0004) begin errors++; $display("FAIL rd_c1_addr: got %h expected 00400004", imem_req_addr); end
        next_cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h0040_0100;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rd_redirect_noreq: got %b expected 0", imem_req_valid); end
        next_cycle();
        redirect_valid = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = word_for(C_RST);
        #1;
        checks++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0040_0100) begin errors++; $display("FAIL rd_discard_credit: got %b/%h expected 0/00400100", imem_req_valid, imem_req_addr); end
        next_cycle();
        imem_rsp_data = word_for(32'h0040_0004);
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0040_0100 || if_valid !== 1'b0) begin errors++; $display("FAIL rd_new_req: got %b/%h/%b expected 1/00400100/0", imem_req_valid, imem_req_addr, if_valid); end
        next_cycle();
        imem_rsp_data = word_for(32'h0040_0100); imem_req_ready = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rd_stale_dropped: got %b expected 0", if_valid); end
        next_cycle();
        imem_rsp_valid = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0040_0100 || if_instr !== word_for(32'h0040_0100)) begin errors++; $display("FAIL rd_target_out: got %b/%h/%h expected 1/00400100/%h", if_valid, if_pc, if_instr, word_for(32'h0040_0100)); end
        next_cycle();
        #1;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rd_after_pop: got %b expected 0", if_valid); end
    endtask

    task automatic test_redirect_collide();
        do_reset();
        imem_req_ready = 1'b1; if_ready = 1'b0;
        next_cycle();
        imem_rsp_valid = 1'b1; imem_rsp_data = word_for(C_RST);
        next_cycle();
        imem_rsp_data = word_for(32'h0040_0004); if_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h0040_0103;
        #1;
        checks++; if (if_valid !== 1'b1 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL rc_collide_cycle: got %b/%b expected 1/0", if_valid, imem_req_valid); end
        next_cycle();
        redirect_valid = 1'b0; imem_rsp_valid = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rc_flushed: got %b expected 0", if_valid); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0040_0100) begin errors++; $display("FAIL rc_aligned_req: got %b/%h expected 1/00400100", imem_req_valid, imem_req_addr); end
        next_cycle();
        imem_rsp_valid = 1'b1; imem_rsp_data = word_for(32'h0040_0100); imem_req_ready = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rc_latency: got %b expected 0", if_valid); end
        next_cycle();
        imem_rsp_valid = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0040_0100 || if_instr !== word_for(32'h0040_0100)) begin errors++; $display("FAIL rc_target_out: got %b/%h/%h expected 1/00400100/%h", if_valid, if_pc, if_instr, word_for(32'h0040_0100)); end
        next_cycle();
    endtask

    task automatic test_reset_midstream();
        do_reset();
        imem_req_ready = 1'b1; if_ready = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL mr_in_reset: got %b expected 0", imem_req_valid); end
        next_cycle();
        reset = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = word_for(C_RST);
        #1;
        checks++; if (imem_req_addr !== C_RST || imem_req_valid !== 1'b1 || if_valid !== 1'b0) begin errors++; $display("FAIL mr_restart: got %h/%b/%b expected %h/1/0", imem_req_addr, imem_req_valid, if_valid, C_RST); end
        next_cycle();
        imem_rsp_data = word_for(32'h0040_0004);
        #1;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL mr_late_rsp0: got %b expected 0", if_valid); end
        next_cycle();
        imem_rsp_valid = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b0 || imem_req_addr !== C_RST) begin errors++; $display("FAIL mr_late_rsp1: got %b/%h expected 0/%h", if_valid, imem_req_addr, C_RST); end
    endtask

    // Bound the whole run in case the design stalls a handshake forever
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drop();
        test_redirect_collide();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_instr_fetch_unit
`default_nettype wire
